// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 cache port between the I-cache miss path
// (read-only) and the D-cache miss/writeback path (read/write). One
// transaction outstanding at a time, round-robin on simultaneous requests.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ic_read, ic_addr      I-cache line read request (held until ic_resp)
//   ic_rdata, ic_resp     I-cache read line and one-cycle completion pulse
//   dc_read, dc_write     D-cache line read/write request (held until dc_resp)
//   dc_addr, dc_wdata     D-cache address and write line
//   dc_rdata, dc_resp     D-cache read line and one-cycle completion pulse
//   l2_read, l2_write     command to L2, driven from the latched transaction
//   l2_addr, l2_wdata     latched address / write line to L2 (0 when idle)
//   l2_rdata, l2_resp     L2 read line and one-cycle completion
module l2_arbiter #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic [s_addr-1:0] ic_addr,
    output logic [s_line-1:0] ic_rdata,
    output logic              ic_resp,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [s_addr-1:0] dc_addr,
    input  logic [s_line-1:0] dc_wdata,
    output logic [s_line-1:0] dc_rdata,
    output logic              dc_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_addr,
    output logic [s_line-1:0] l2_wdata,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } state_t;

    state_t            state, state_next;
    logic              last_grant, last_grant_next;   // 0 = I, 1 = D
    logic [s_addr-1:0] addr_q, addr_next;
    logic [s_line-1:0] wdata_q, wdata_next;
    logic              dir_q, dir_next;               // 1 = write
    logic              i_req, d_req;

    assign i_req = ic_read;
    assign d_req = dc_read | dc_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            dir_q      <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            dir_q      <= dir_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        dir_next        = dir_q;
        case (state)
            IDLE: begin
                // D wins when it is alone, or on a tie when I was served last.
                if (d_req && (!i_req || !last_grant)) begin
                    state_next      = D_BUSY;
                    last_grant_next = 1'b1;
                    addr_next       = dc_addr;
                    wdata_next      = dc_wdata;
                    dir_next        = dc_write;   // read+write together is a write
                end else if (i_req) begin
                    state_next      = I_BUSY;
                    last_grant_next = 1'b0;
                    addr_next       = ic_addr;
                    wdata_next      = '0;
                    dir_next        = 1'b0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (l2_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Downstream command depends only on state and latched registers so that
    // upstream changes after the grant cannot disturb the L2 controller.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        ic_resp  = 1'b0;
        dc_resp  = 1'b0;
        ic_rdata = '0;
        dc_rdata = '0;
        case (state)
            I_BUSY: begin
                l2_read  = 1'b1;
                l2_addr  = addr_q;
                l2_wdata = wdata_q;
                ic_resp  = l2_resp;
                ic_rdata = l2_rdata;
            end
            D_BUSY: begin
                l2_read  = !dir_q;
                l2_write = dir_q;
                l2_addr  = addr_q;
                l2_wdata = wdata_q;
                dc_resp  = l2_resp;
                dc_rdata = l2_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_read;
    logic [31:0]  ic_addr;
    logic [255:0] ic_rdata;
    logic         ic_resp;
    logic         dc_read;
    logic         dc_write;
    logic [31:0]  dc_addr;
    logic [255:0] dc_wdata;
    logic [255:0] dc_rdata;
    logic         dc_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_addr;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    l2_arbiter #(.s_line(256), .s_addr(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ic_read  (ic_read),
        .ic_addr  (ic_addr),
        .ic_rdata (ic_rdata),
        .ic_resp  (ic_resp),
        .dc_read  (dc_read),
        .dc_write (dc_write),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_rdata (dc_rdata),
        .dc_resp  (dc_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_resp  (l2_resp)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata;
        q.push_back(e);
    endtask

    task automatic check_cmd(input string tag, input exp_t e);
        chk1({tag, "_rd"}, l2_read, !e.wr);
        chk1({tag, "_wr"}, l2_write, e.wr);
        chkw({tag, "_addr"}, 256'(l2_addr), 256'(e.addr));
        if (e.is_d) chkw({tag, "_wdata"}, l2_wdata, e.wdata);
    endtask

    // Acts as the L2 controller for one transaction: waits (bounded) for the
    // command, checks it against the scoreboard head, holds for lat cycles,
    // responds with rd, checks the upstream pulse and then drops the request.
    task automatic serve(input int exp_wait, input int lat, input logic [255:0] rd,
                         input bit corrupt);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!(l2_read || l2_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("cmd_seen", l2_read | l2_write, 1'b1);
        if (exp_wait >= 0) chkw("cmd_latency", 256'(n), 256'(exp_wait));
        if (q.size() == 0) begin
            chk1("sb_nonempty", 1'b0, 1'b1);
            return;
        end
        e = q.pop_front();
        check_cmd("grant", e);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            if (corrupt && i == 0) begin
                dc_addr  = 32'hDEAD_BEEF;
                dc_wdata = '1;
                ic_addr  = 32'hCAFE_0000;
            end
            @(negedge clk);
            check_cmd("hold", e);
            chk1("hold_ic_resp", ic_resp, 1'b0);
            chk1("hold_dc_resp", dc_resp, 1'b0);
        end
        @(posedge clk); #1;
        l2_resp  = 1'b1;
        l2_rdata = rd;
        @(negedge clk);
        chk1("ic_resp", ic_resp, !e.is_d);
        chk1("dc_resp", dc_resp, e.is_d);
        chkw("ic_rdata", ic_rdata, e.is_d ? 256'h0 : rd);
        chkw("dc_rdata", dc_rdata, e.is_d ? rd : 256'h0);
        @(posedge clk); #1;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        if (e.is_d) begin
            dc_read  = 1'b0;
            dc_write = 1'b0;
        end else begin
            ic_read = 1'b0;
        end
        @(negedge clk);
        chk1("post_ic_resp", ic_resp, 1'b0);
        chk1("post_dc_resp", dc_resp, 1'b0);
        chk1("post_idle_rd", l2_read, 1'b0);
        chk1("post_idle_wr", l2_write, 1'b0);
        chkw("post_idle_addr", 256'(l2_addr), 256'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ic_read  = 1'b1;
        ic_addr  = 32'h0000_0100;
        dc_read  = 1'b0;
        dc_write = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        l2_rdata = '0;
        l2_resp  = 1'b0;

        // Reset held two cycles with an I request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_l2_read", l2_read, 1'b0);
        chk1("rst_l2_write", l2_write, 1'b0);
        chkw("rst_l2_addr", 256'(l2_addr), 256'h0);
        chkw("rst_l2_wdata", l2_wdata, 256'h0);
        chk1("rst_ic_resp", ic_resp, 1'b0);
        chk1("rst_dc_resp", dc_resp, 1'b0);
        rst_n = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0100, '0);
        serve(0, 2, 256'h77, 1'b0);

        // Single I read, response after 5 cycles.
        ic_addr = 32'h0000_1000;
        ic_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_1000, '0);
        serve(0, 5, {32{8'hA5}}, 1'b0);

        // D write (read also high: still a write), upstream corrupted after grant.
        dc_addr  = 32'h8000_0040;
        dc_wdata = 256'h1234;
        dc_write = 1'b1;
        dc_read  = 1'b1;
        push(1'b1, 1'b1, 32'h8000_0040, 256'h1234);
        serve(0, 3, 256'hFFFF, 1'b1);

        // Spurious response while idle.
        l2_resp  = 1'b1;
        l2_rdata = '1;
        #1;
        chk1("spur_ic_resp", ic_resp, 1'b0);
        chk1("spur_dc_resp", dc_resp, 1'b0);
        chkw("spur_ic_rdata", ic_rdata, 256'h0);
        @(posedge clk); #1;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        @(negedge clk);
        chk1("spur_stay_idle_rd", l2_read, 1'b0);
        chk1("spur_stay_idle_wr", l2_write, 1'b0);

        // Continuous requests from both: grants alternate I, D, I, D.
        ic_addr  = 32'h0000_2000;
        dc_addr  = 32'h0000_3000;
        dc_wdata = 256'h55;
        ic_read  = 1'b1;
        dc_read  = 1'b1;
        push(1'b0, 1'b0, 32'h0000_2000, '0);
        push(1'b1, 1'b0, 32'h0000_3000, 256'h55);
        push(1'b0, 1'b0, 32'h0000_2000, '0);
        push(1'b1, 1'b0, 32'h0000_3000, 256'h55);
        serve(0, 1, 256'h101, 1'b0);
        ic_read = 1'b1;
        serve(0, 1, 256'h202, 1'b0);
        dc_read = 1'b1;
        serve(0, 1, 256'h303, 1'b0);
        serve(0, 1, 256'h404, 1'b0);

        // Reset during a D transaction, then a tie after release.
        dc_addr = 32'h0000_4000;
        dc_read = 1'b1;
        @(negedge clk);
        chk1("mid_d_granted", l2_read, 1'b1);
        chkw("mid_d_addr", 256'(l2_addr), 256'h4000);
        rst_n   = 1'b0;
        ic_read = 1'b1;
        @(negedge clk);
        chk1("mid_rst_rd", l2_read, 1'b0);
        chk1("mid_rst_wr", l2_write, 1'b0);
        l2_resp = 1'b1;
        #1;
        chk1("mid_rst_dc_resp", dc_resp, 1'b0);
        chk1("mid_rst_ic_resp", ic_resp, 1'b0);
        l2_resp = 1'b0;
        rst_n   = 1'b1;
        push(1'b0, 1'b0, 32'h0000_2000, '0);
        push(1'b1, 1'b0, 32'h0000_4000, 256'h55);
        serve(0, 2, 256'h505, 1'b0);
        serve(0, 2, 256'h606, 1'b0);

        chkw("sb_drained", 256'(q.size()), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-port arbiter sharing the single L2 cache port between the I-cache miss path (read-only) and the D-cache miss/writeback path (read/write).
- One transaction outstanding at a time; round-robin fairness when both request.
- Sits between the L1 caches and the L2 cache controller, which owns the L2 tag/data/LRU arrays.
- Latches the winner's command so downstream signals stay stable until L2 responds.

Parameters:
- s_line, 256, cache line width in bits (rdata/wdata width)
- s_addr, 32, address width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- ic_read  in  1  I-cache line read request, held until ic_resp
- ic_addr  in  s_addr  I-cache line address
- ic_rdata  out  s_line  read line to I-cache
- ic_resp  out  1  one-cycle completion pulse to I-cache
- dc_read  in  1  D-cache line read request, held until dc_resp
- dc_write  in  1  D-cache line write request, held until dc_resp
- dc_addr  in  s_addr  D-cache line address
- dc_wdata  in  s_line  D-cache write line
- dc_rdata  out  s_line  read line to D-cache
- dc_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- l2_addr  out  s_addr  latched address to L2
- l2_wdata  out  s_line  latched write line to L2
- l2_rdata  in  s_line  L2 read line
- l2_resp  in  1  L2 completion, one cycle

Behaviour:
- Clock is clk; reset is synchronous, active-low.
- States: IDLE, I_BUSY, D_BUSY. Register last_grant (0=I, 1=D).
- Reset (rst_n=0 at an edge):
  - state=IDLE, last_grant=D (I-cache wins the first tie).
  - Latched addr/wdata/dir = 0.
  - All outputs 0.
  - Any in-flight transaction is abandoned without a resp; the L2 controller is reset on the same rst_n.
- IDLE, arbitration sampled at each edge:
  - I request only = ic_read. D request = dc_read|dc_write.
  - Only I requests: go to I_BUSY, last_grant<=I.
  - Only D requests: go to D_BUSY, last_grant<=D.
  - Both request: grant the requester not equal to last_grant, then update last_grant.
  - Neither requests: stay in IDLE.
  - On grant, latch addr, wdata, and dir into internal registers. D-cache dir=write if dc_write=1; dc_read and dc_write both high is treated as a write.
- Outputs:
  - l2_read/l2_write are driven from state plus the latched dir only, never from upstream inputs.
  - I_BUSY: l2_read=1.
  - D_BUSY: l2_read=!dir, l2_write=dir.
  - l2_addr/l2_wdata come from the latched registers and are 0 in IDLE.
  - Upstream changes after grant have no effect.
- Latency:
  - Request visible in cycle N → L2 command asserted in cycle N+1.
  - Command held until the cycle in which l2_resp=1.
- Completion:
  - ic_resp = (state==I_BUSY)&l2_resp; dc_resp = (state==D_BUSY)&l2_resp. Both are combinational, same cycle as l2_resp.
  - ic_rdata/dc_rdata = l2_rdata while in the matching BUSY state, else 0.
  - The edge after l2_resp returns to IDLE.
- Turnaround: at least one IDLE cycle between transactions; the requester must drop its request in the cycle after resp.
- l2_resp while in IDLE is ignored; no upstream resp is generated.
- No timeout: a BUSY state waits indefinitely for l2_resp.
- ic_resp and dc_resp are never asserted in the same cycle.

Test Plan:
- Reset: hold rst_n=0 two cycles with ic_read=1 → all outputs 0 and state IDLE. Release → l2_read=1, l2_addr=ic_addr on the cycle after first sampling rst_n=1.
- Single I read: ic_addr=0x0000_1000, L2 returns l2_rdata=256'hA5..A5 with l2_resp after 5 cycles → ic_resp=1 for exactly one cycle with ic_rdata=A5..A5. dc_resp stays 0 and l2_write stays 0 throughout.
- D write with input corruption: dc_write=1, dc_addr=0x8000_0040, dc_wdata=256'h1234; change dc_addr/dc_wdata the cycle after grant → l2_write=1, l2_addr=0x8000_0040, l2_wdata=256'h1234 stable until l2_resp; then dc_resp pulses.
- Simultaneous requests after reset: ic_read=1 and dc_read=1 held → I served first. After ic_resp and one IDLE cycle, D is served. With both re-asserted continuously, grants alternate I, D, I, D.
- Spurious response: l2_resp=1 while IDLE with no requests → ic_resp=dc_resp=0 and state stays IDLE.
- Mid-transaction reset: assert rst_n=0 during D_BUSY before l2_resp → next cycle l2_read=l2_write=0, no dc_resp. After release with both requesting, I wins (last_grant reset to D).
